// File: rtl/disk_pkg.sv
// Shared types and size helpers for the sector-addressed disk model.
package disk_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSeek,
      StXferRd,
      StXferWr,
      StDone
   } state_e;

   function automatic int unsigned sect_width(input int unsigned addr_width,
                                              input int unsigned sector_bits);
      return addr_width - sector_bits;
   endfunction

   function automatic int unsigned sector_words(input int unsigned sector_bits);
      return 1 << sector_bits;
   endfunction

endpackage

// File: rtl/disk_array.sv
// Single-port word array: synchronous write, combinational read.
module disk_array #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 15,
   parameter string       INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/disk_sector_ctrl.sv
// Sector-granular disk controller: seek latency model plus valid/ready word streaming.
module disk_sector_ctrl
   import disk_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH  = 15,
   parameter int unsigned SECTOR_BITS = 4,
   parameter int unsigned SEEK_CYCLES = 8,
   parameter string       INIT_FILE   = "",
   localparam int unsigned SECT_W     = sect_width(ADDR_WIDTH, SECTOR_BITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [SECT_W-1:0]     cmd_sector,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  busy,
   output logic                  done,
   output logic [SECT_W-1:0]     head
);

   localparam int unsigned CNT_W = (SEEK_CYCLES > 1) ? $clog2(SEEK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SEEK_LOAD = CNT_W'((SEEK_CYCLES > 0) ? SEEK_CYCLES - 1 : 0);
   localparam logic [SECTOR_BITS-1:0] LAST_IDX = '1;
   localparam logic [SECTOR_BITS-1:0] IDX_ZERO = '0;

   state_e                  state;
   logic [SECT_W-1:0]       sect;
   logic [SECTOR_BITS-1:0]  idx;
   logic [SECTOR_BITS-1:0]  idx_next;
   logic [CNT_W-1:0]        seek_cnt;
   logic                    is_write;
   logic [ADDR_WIDTH-1:0]   arr_addr;
   logic [DATA_WIDTH-1:0]   arr_rdata;
   logic                    arr_we;

   assign idx_next = idx + SECTOR_BITS'(1);
   assign arr_we   = (state == StXferWr) && wr_valid;

   // Read address looks one word ahead so rd_data is loaded on the same edge it is consumed.
   always_comb begin
      arr_addr = {sect, idx};
      case (state)
         StIdle:   arr_addr = {cmd_sector, IDX_ZERO};
         StSeek:   arr_addr = {sect, IDX_ZERO};
         StXferRd: arr_addr = {sect, idx_next};
         default:  arr_addr = {sect, idx};
      endcase
   end

   disk_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (wr_data),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_valid  <= 1'b0;
         wr_ready  <= 1'b0;
         rd_data   <= '0;
         head      <= '0;
         idx       <= '0;
         sect      <= '0;
         is_write  <= 1'b0;
         seek_cnt  <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (cmd_valid) begin
                  sect      <= cmd_sector;
                  is_write  <= cmd_write;
                  idx       <= '0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_sector == head || SEEK_CYCLES == 0) begin
                     if (cmd_write) begin
                        state    <= StXferWr;
                        wr_ready <= 1'b1;
                     end else begin
                        state    <= StXferRd;
                        rd_valid <= 1'b1;
                        rd_data  <= arr_rdata;
                     end
                  end else begin
                     state    <= StSeek;
                     seek_cnt <= SEEK_LOAD;
                  end
               end
            end
            StSeek: begin
               if (seek_cnt == '0) begin
                  head <= sect;
                  if (is_write) begin
                     state    <= StXferWr;
                     wr_ready <= 1'b1;
                  end else begin
                     state    <= StXferRd;
                     rd_valid <= 1'b1;
                     rd_data  <= arr_rdata;
                  end
               end else begin
                  seek_cnt <= seek_cnt - CNT_W'(1);
               end
            end
            StXferRd: begin
               if (rd_ready) begin
                  if (idx == LAST_IDX) begin
                     rd_valid <= 1'b0;
                     done     <= 1'b1;
                     state    <= StDone;
                  end else begin
                     idx     <= idx_next;
                     rd_data <= arr_rdata;
                  end
               end
            end
            StXferWr: begin
               if (wr_valid) begin
                  if (idx == LAST_IDX) begin
                     wr_ready <= 1'b0;
                     done     <= 1'b1;
                     state    <= StDone;
                  end else begin
                     idx <= idx_next;
                  end
               end
            end
            StDone: begin
               done      <= 1'b0;
               head      <= sect + SECT_W'(1);
               idx       <= '0;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_disk_sector_ctrl.sv
// Randomized bench for disk_sector_ctrl against a word-level memory and head-position model.
module tb_disk_sector_ctrl;

   localparam int DW   = 16;
   localparam int AW   = 15;
   localparam int SB   = 4;
   localparam int SW   = AW - SB;
   localparam int SEEK = 8;
   localparam int WPS  = 1 << SB;
   localparam int NSEC = 1 << SW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [SW-1:0] cmd_sector;
   logic [DW-1:0] wr_data;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_ready;
   logic          busy;
   logic          done;
   logic [SW-1:0] head;

   always #5 clk = ~clk;

   disk_sector_ctrl #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .SECTOR_BITS (SB),
      .SEEK_CYCLES (SEEK),
      .INIT_FILE   ("")
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_sector (cmd_sector),
      .wr_data    (wr_data),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .busy       (busy),
      .done       (done),
      .head       (head)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: word contents by address, plus where the head sits.
   logic [DW-1:0] mem_model [int];
   int            model_head;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, ".cmd_ready"}, 32'(cmd_ready), 1);
      check_eq({tag, ".busy"},      32'(busy), 0);
      check_eq({tag, ".done"},      32'(done), 0);
      check_eq({tag, ".rd_valid"},  32'(rd_valid), 0);
      check_eq({tag, ".wr_ready"},  32'(wr_ready), 0);
      check_eq({tag, ".rd_data"},   32'(rd_data), 0);
      check_eq({tag, ".head"},      32'(head), 0);
   endtask

   function automatic int exp_seek(input int s);
      return (s == model_head || SEEK == 0) ? 0 : SEEK;
   endfunction

   function automatic bit sector_known(input int s);
      for (int i = 0; i < WPS; i++) if (!mem_model.exists(s * WPS + i)) return 1'b0;
      return 1'b1;
   endfunction

   // Presents a command for one edge; returns at the negedge after acceptance.
   task automatic issue(input bit wr, input int s);
      @(negedge clk);
      check_eq("cmd_ready_idle", 32'(cmd_ready), 1);
      cmd_valid  = 1'b1;
      cmd_write  = wr;
      cmd_sector = SW'(s);
      @(negedge clk);
      cmd_valid  = 1'b0;
   endtask

   task automatic wait_xfer(input bit wr, input int exp_s);
      int seen = 0;
      while (((wr ? wr_ready : rd_valid) !== 1'b1) && seen < 64) begin
         check_eq("busy_seek", 32'(busy), 1);
         seen++;
         @(negedge clk);
      end
      check_eq(wr ? "seek_cycles_wr" : "seek_cycles_rd", seen, exp_s);
   endtask

   task automatic finish_cmd(input int s);
      check_eq("done_pulse", 32'(done), 1);
      check_eq("rd_valid_done", 32'(rd_valid), 0);
      check_eq("wr_ready_done", 32'(wr_ready), 0);
      @(negedge clk);
      check_eq("done_cleared", 32'(done), 0);
      check_eq("busy_idle", 32'(busy), 0);
      check_eq("head_after", 32'(head), (s + 1) % NSEC);
      model_head = (s + 1) % NSEC;
   endtask

   task automatic do_write(input int s, input logic [DW-1:0] data [WPS], input int abort_at,
                           input bit poke_cmd);
      int n = 0;
      int guard = 0;
      int es = exp_seek(s);
      issue(1'b1, s);
      wait_xfer(1'b1, es);
      while (n < WPS && guard < 500) begin
         if (n == abort_at) break;
         check_eq("wr_ready_xfer", 32'(wr_ready), 1);
         if (poke_cmd) begin
            check_eq("cmd_ready_xfer", 32'(cmd_ready), 0);
            cmd_valid = (n < WPS - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         wr_valid = ($urandom_range(0, 3) != 0);
         wr_data  = data[n];
         @(negedge clk);
         if (wr_valid) begin
            mem_model[s * WPS + n] = data[n];
            n++;
         end
         guard++;
      end
      wr_valid  = 1'b0;
      cmd_valid = 1'b0;
      if (abort_at >= 0) begin
         rst_n = 1'b0;
         #1;
         check_reset_vals("abort_wr");
         model_head = 0;
         @(negedge clk);
         rst_n = 1'b1;
      end else begin
         check_eq("wr_count", n, WPS);
         finish_cmd(s);
      end
   endtask

   task automatic do_read(input int s, input bit pattern);
      int n = 0;
      int cyc = 0;
      int es = exp_seek(s);
      issue(1'b0, s);
      wait_xfer(1'b0, es);
      while (n < WPS && cyc < 500) begin
         check_eq("rd_valid_xfer", 32'(rd_valid), 1);
         if (mem_model.exists(s * WPS + n))
            check_eq($sformatf("rd_data[s%0d w%0d]", s, n), 32'(rd_data), 32'(mem_model[s * WPS + n]));
         rd_ready = pattern ? !((cyc % 4) == 1 || (cyc % 4) == 2) : ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (rd_ready) n++;
         cyc++;
      end
      rd_ready = 1'b0;
      check_eq("rd_count", n, WPS);
      finish_cmd(s);
   endtask

   logic [DW-1:0] buf_data [WPS];

   initial begin
      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_write  = 1'b0;
      cmd_sector = '0;
      wr_data    = '0;
      wr_valid   = 1'b0;
      rd_ready   = 1'b0;
      model_head = 0;
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      rst_n = 1'b1;

      // Sector 0 written at head 0, then reset during a seek, then read back without seek.
      for (int i = 0; i < WPS; i++) buf_data[i] = DW'($urandom);
      do_write(0, buf_data, -1, 1'b0);
      issue(1'b0, 9);
      repeat (3) begin
         check_eq("mid_seek_busy", 32'(busy), 1);
         check_eq("mid_seek_rd_valid", 32'(rd_valid), 0);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check_reset_vals("abort_seek");
      model_head = 0;
      @(negedge clk);
      rst_n = 1'b1;
      do_read(0, 1'b0);

      // Sector 5 known pattern, sequential sector 6, then read both; stall pattern on 6.
      for (int i = 0; i < WPS; i++) buf_data[i] = DW'(16'h0100 + i);
      do_write(5, buf_data, -1, 1'b0);
      for (int i = 0; i < WPS; i++) buf_data[i] = DW'($urandom);
      do_write(6, buf_data, -1, 1'b0);
      do_read(5, 1'b0);
      do_read(6, 1'b1);

      // Max sector wraps the head; command requests during transfer are ignored.
      for (int i = 0; i < WPS; i++) buf_data[i] = DW'($urandom);
      do_write(NSEC - 1, buf_data, -1, 1'b1);

      // Partial write to sector 3 aborted by reset after 7 words.
      for (int i = 0; i < WPS; i++) buf_data[i] = DW'(16'h3300 + i);
      do_write(3, buf_data, -1, 1'b0);
      for (int i = 0; i < WPS; i++) buf_data[i] = DW'(16'hA500 + i);
      do_write(3, buf_data, 7, 1'b0);
      do_read(3, 1'b0);

      for (int k = 0; k < 16; k++) begin
         int s;
         s = ($urandom_range(0, 7) == 0) ? NSEC - 1 : int'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1 || !sector_known(s)) begin
            for (int i = 0; i < WPS; i++) buf_data[i] = DW'($urandom);
            do_write(s, buf_data, -1, 1'($urandom_range(0, 1)));
         end else begin
            do_read(s, 1'($urandom_range(0, 1)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
